// File: rtl/scsp_dma_ctrl.sv
// scsp_dma_ctrl: sequencer for the SCSP internal DMA engine.
// Moves 16-bit words between sound RAM and the SCSP register space, one
// request at a time, and pulses the DMA-end interrupt at completion.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   DMEA, DRGA, DTLG         RAM word address, register word address, length
//   DDIR, DGATE, DEXE_SET    direction, zero-fill gate, start pulse
//   BUSY, DONE_IRQ           DEXE readback, one-cycle end-of-transfer pulse
//   MEM_REQ/WE/ADDR/DO/DI/ACK  sound-RAM arbiter handshake
//   REG_REQ/WE/ADDR/DO/DI/ACK  register-bus arbiter handshake
module scsp_dma_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [18:0] DMEA,
  input  logic [10:0] DRGA,
  input  logic [10:0] DTLG,
  input  logic        DDIR,
  input  logic        DGATE,
  input  logic        DEXE_SET,
  output logic        BUSY,
  output logic        DONE_IRQ,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [18:0] MEM_ADDR,
  output logic [15:0] MEM_DO,
  input  logic [15:0] MEM_DI,
  input  logic        MEM_ACK,
  output logic        REG_REQ,
  output logic        REG_WE,
  output logic [10:0] REG_ADDR,
  output logic [15:0] REG_DO,
  input  logic [15:0] REG_DI,
  input  logic        REG_ACK
);

  localparam int unsigned MA_W   = 19;
  localparam int unsigned RA_W   = 11;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // Working registers latched at start; the CR inputs are ignored afterwards.
  logic [MA_W-1:0]     ma;
  logic [RA_W-1:0]     ra;
  logic [CNT_W-1:0]    cnt;
  logic                dir;
  logic                gate;
  logic [DATA_W-1:0]   hold;

  // Source side is RAM for dir=0 and the register bus for dir=1; the
  // destination is always the other side. An ACK only counts while its own
  // REQ is the one being driven, so strays on the idle side are ignored.
  logic                src_ack;
  logic                dst_ack;
  logic [DATA_W-1:0]   src_di;
  logic [DATA_W-1:0]   wr_data;

  assign src_ack = dir ? REG_ACK : MEM_ACK;
  assign dst_ack = dir ? MEM_ACK : REG_ACK;
  assign src_di  = dir ? REG_DI  : MEM_DI;
  assign wr_data = gate ? DATA_W'(0) : hold;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (DEXE_SET) begin
          if (DTLG == CNT_W'(0)) begin
            state_nxt = ST_DONE;
          end else if (DGATE) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (src_ack) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (dst_ack) begin
          state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // cnt is decremented on this edge, so a value of 1 means it becomes 0.
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end else if (gate) begin
          state_nxt = ST_WRITE;
        end else begin
          state_nxt = ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Working registers: latch at start, capture read data, advance per word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ma   <= '0;
      ra   <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
      gate <= 1'b0;
      hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (DEXE_SET) begin
            ma   <= DMEA;
            ra   <= DRGA;
            cnt  <= DTLG;
            dir  <= DDIR;
            gate <= DGATE;
          end
        end
        ST_READ: begin
          if (src_ack) begin
            hold <= src_di;
          end
        end
        ST_NEXT: begin
          ma  <= ma + MA_W'(1);
          ra  <= ra + RA_W'(1);
          cnt <= cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state and working registers only. Address, WE and
  // data come from registers that do not change while in READ/WRITE, so they
  // stay stable for the whole request.
  always_comb begin
    BUSY     = 1'b0;
    DONE_IRQ = 1'b0;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    MEM_DO   = '0;
    REG_REQ  = 1'b0;
    REG_WE   = 1'b0;
    REG_ADDR = '0;
    REG_DO   = '0;

    BUSY     = (state != ST_IDLE);
    DONE_IRQ = (state == ST_DONE);

    case (state)
      ST_READ: begin
        if (dir) begin
          REG_REQ  = 1'b1;
          REG_ADDR = ra;
        end else begin
          MEM_REQ  = 1'b1;
          MEM_ADDR = ma;
        end
      end
      ST_WRITE: begin
        if (dir) begin
          MEM_REQ  = 1'b1;
          MEM_WE   = 1'b1;
          MEM_ADDR = ma;
          MEM_DO   = wr_data;
        end else begin
          REG_REQ  = 1'b1;
          REG_WE   = 1'b1;
          REG_ADDR = ra;
          REG_DO   = wr_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
